// File: rtl/uart_loader_pkg.sv
// Shared types and helpers for the UART boot loader: FSM states, framing
// constants and the byte-enable mask derived from a lane count.
package uart_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_BYTES      = 4;

  // Low n lanes enabled; a full word enables all four.
  function automatic logic [3:0] wmask_from_count(input logic [2:0] count);
    if (count >= 3'(BYTES_PER_WORD)) return 4'b1111;
    return 4'((5'd1 << count) - 5'd1);
  endfunction

endpackage

// File: rtl/uart_word_packer.sv
// Packs a byte stream into a 32-bit little-endian word; the byte written
// at lane_count k lands in bits [8k+7:8k].
module uart_word_packer
  import uart_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  input  logic        clear_i,
  output logic [31:0] word_o,
  output logic [2:0]  lane_count_o,
  output logic        full_o
);

  logic [31:0] word_q;
  logic [2:0]  count_q;

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q  <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      word_q  <= '0;
      count_q <= '0;
    end else if (byte_valid_i && !full_o) begin
      word_q[8*count_q[1:0] +: 8] <= byte_i;
      count_q                     <= count_q + 3'd1;
    end
  end

  assign word_o       = word_q;
  assign lane_count_o = count_q;
  assign full_o       = (count_q == 3'(BYTES_PER_WORD));

endmodule

// File: rtl/uart_boot_loader.sv
// Boot loader: parses a 4-byte little-endian length header from the UART
// byte stream and writes the payload to memory as 32-bit valid/ready words.
module uart_boot_loader
  import uart_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] MAX_BYTES = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        busy,
  output logic        done,
  output logic        err_overflow,
  output logic        err_toobig
);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] remaining_q, remaining_d;
  logic [31:0] len_q, len_d;
  logic [1:0]  hdr_cnt_q, hdr_cnt_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d;
  logic        toobig_q, toobig_d;
  logic        busy_q, mem_valid_q;

  logic [7:0]  pk_byte;
  logic        pk_valid, pk_clear, pk_full;
  logic [31:0] pk_word;
  logic [2:0]  pk_count;
  logic [31:0] len_full;

  uart_word_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .byte_i       (pk_byte),
    .byte_valid_i (pk_valid),
    .clear_i      (pk_clear),
    .word_o       (pk_word),
    .lane_count_o (pk_count),
    .full_o       (pk_full)
  );

  assign len_full = {rx_data, len_q[31:8]};

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    len_d       = len_q;
    hdr_cnt_d   = hdr_cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    done_d      = done_q;
    ovf_d       = ovf_q;
    toobig_d    = toobig_q;
    pk_byte     = rx_data;
    pk_valid    = 1'b0;
    pk_clear    = 1'b0;

    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d     = LEN;
          done_d      = 1'b0;
          ovf_d       = 1'b0;
          toobig_d    = 1'b0;
          addr_d      = BASE_ADDR;
          hdr_cnt_d   = '0;
          len_d       = '0;
          remaining_d = '0;
          hold_full_d = 1'b0;
          pk_clear    = 1'b1;
        end
      end

      LEN: begin
        if (rx_valid) begin
          len_d     = len_full;
          hdr_cnt_d = hdr_cnt_q + 2'd1;
          if (hdr_cnt_q == 2'(HDR_BYTES - 1)) begin
            if (len_full > MAX_BYTES) begin
              state_d  = ERR;
              toobig_d = 1'b1;
            end else if (len_full == '0) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d     = DATA;
              remaining_d = len_full;
            end
          end
        end
      end

      DATA: begin
        if (hold_full_q || rx_valid) begin
          pk_valid    = 1'b1;
          pk_byte     = hold_full_q ? hold_q : rx_data;
          remaining_d = (remaining_q != '0) ? remaining_q - 32'd1 : '0;
          if (pk_count == 3'(BYTES_PER_WORD - 1) || remaining_q <= 32'd1)
            state_d = WRITE;
          // Draining the hold frees it for a concurrent byte unless that byte is surplus.
          if (hold_full_q) begin
            hold_full_d = rx_valid && (remaining_q > 32'd1);
            if (rx_valid) hold_d = rx_data;
          end
        end
      end

      WRITE: begin
        if (mem_ready) begin
          addr_d   = addr_q + 32'(BYTES_PER_WORD);
          pk_clear = 1'b1;
          if (remaining_q == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = DATA;
          end
        end
        // A byte is surplus once the hold already covers every byte still owed.
        if (rx_valid && (remaining_q != {31'b0, hold_full_q})) begin
          if (!hold_full_q) begin
            hold_d      = rx_data;
            hold_full_d = 1'b1;
          end else begin
            state_d = ERR;
            ovf_d   = 1'b1;
            done_d  = 1'b0;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      len_q       <= '0;
      hdr_cnt_q   <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      toobig_q    <= 1'b0;
      busy_q      <= 1'b0;
      mem_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      len_q       <= len_d;
      hdr_cnt_q   <= hdr_cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      toobig_q    <= toobig_d;
      busy_q      <= (state_d == LEN) || (state_d == DATA) || (state_d == WRITE);
      mem_valid_q <= (state_d == WRITE);
    end
  end

  assign mem_addr     = addr_q;
  assign mem_wdata    = pk_word;
  assign mem_wmask    = pk_full ? 4'b1111 : wmask_from_count(pk_count);
  assign mem_valid    = mem_valid_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err_overflow = ovf_q;
  assign err_toobig   = toobig_q;

endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
Controller that sequences the UART receive datapath to load a program image into memory at boot.
- Consumes the receiver's byte stream (rdata plus a one-cycle rdata_valid pulse).
- Parses a 4-byte little-endian length header, then packs the payload bytes into 32-bit words.
- Issues each word as a valid/ready memory write.
- Sits between the UART receiver and the instruction/data memory write port; the CPU is held until done.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first payload word; must be 4-byte aligned.
- MAX_BYTES, 32'h0001_0000, largest accepted payload length in bytes.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  one-cycle pulse; arms the loader. Ignored unless in IDLE, DONE or ERR.
- rx_data  in  8  received byte from the UART receiver.
- rx_valid  in  1  one-cycle pulse; rx_data is valid this cycle.
- mem_addr  out  32  word write address.
- mem_wdata  out  32  write data, little-endian byte packing.
- mem_wmask  out  4  byte enables.
- mem_valid  out  1  write request.
- mem_ready  in  1  memory accepts the write this cycle.
- busy  out  1  high in LEN, DATA and WRITE.
- done  out  1  sticky; high in DONE.
- err_overflow  out  1  sticky; a byte was lost.
- err_toobig  out  1  sticky; header length exceeds MAX_BYTES.

Behaviour:
- Reset: state IDLE, all outputs 0, internal counters, holding register and packer cleared. Reset mid-operation aborts immediately; no further mem_valid is issued.
- States: IDLE, LEN, DATA, WRITE, DONE, ERR.
- start in IDLE/DONE/ERR:
  - go to LEN and clear done and both error flags;
  - set addr = BASE_ADDR, header byte count = 0.
- Bytes arriving in IDLE, DONE or ERR are dropped silently.
- LEN:
  - each rx_valid shifts in one byte: byte 0 is the LSB.
  - On the 4th byte, evaluate the completed length L:
    - L > MAX_BYTES -> ERR with err_toobig = 1;
    - L == 0 -> DONE, done = 1 on the next cycle;
    - otherwise -> DATA with remaining = L.
- DATA, byte source selection:
  - if the holding register is full, it is the byte source; any rx_valid in the same cycle is written into the holding register;
  - otherwise rx_valid is the byte source.
- DATA, byte placement:
  - byte k of the current word goes to lane k (wdata[8k+7:8k]); remaining is decremented.
  - When lane 3 is written, or remaining reaches 0, go to WRITE.
  - mem_valid rises the cycle after the completing byte.
- WRITE:
  - mem_valid = 1; mem_addr, mem_wdata and mem_wmask are held stable until mem_ready is sampled high.
  - mem_wmask = 4'b1111 for full words. For the final partial word it has the low n bits set (n = bytes in the word); unused lanes are 0.
  - On the accepting edge, mem_valid drops the next cycle, mem_addr += 4 and the packer clears.
  - Next state: remaining == 0 -> DONE; else -> DATA.
- Holding register (1 byte):
  - rx_valid while in WRITE fills the holding register if it is empty.
  - If the holding register is already full -> ERR with err_overflow = 1, no further writes, mem_valid deasserts.
  - Same rule in DATA: a byte arriving when hold is full and hold is being consumed is legal (refill); otherwise it is an overflow.
- Extra bytes after the final byte (remaining == 0) are dropped and are not errors.
- start while busy is ignored.
- Arithmetic:
  - remaining is 32-bit and never underflows; the counter saturates at 0.
  - mem_addr wraps modulo 2^32 without a flag.

Decomposition:
- Package uart_loader_pkg:
  - state enum (IDLE, LEN, DATA, WRITE, DONE, ERR);
  - constants BYTES_PER_WORD = 4 and HDR_BYTES = 4;
  - the wmask-from-count function.
- Sub-module uart_word_packer:
  - lane counter and 32-bit assembly register;
  - inputs: byte, byte_valid, clear;
  - outputs: word, lane_count, full.
- The top module owns the FSM, holding register, address and length counters.

Test Plan:
- start; header 08 00 00 00; payload 11 22 33 44 55 66 77 88 -> two writes:
  - 0x44332211 @BASE, mask 1111;
  - 0x88776655 @BASE+4, mask 1111;
  - then done = 1, busy = 0.
- Header 05 00 00 00; payload 11..55 -> 0x44332211 mask 1111, then 0x00000055 @BASE+4 mask 0001; done.
- Header 00 00 00 00 -> no mem_valid; done = 1 the cycle after the 4th header byte.
- Length 8, mem_ready held low 40 cycles after the first word while bytes arrive every 10 cycles:
  - first extra byte is held;
  - second extra byte sets err_overflow;
  - mem_valid drops; done stays 0.
- Header 01 00 01 00 (0x10001 > MAX_BYTES) -> err_toobig = 1, zero writes, busy = 0.
- rst_n low for 1 cycle mid-DATA -> all outputs 0 next cycle; a new start plus the 8-byte image completes correctly from BASE.
